// File: rtl/prio_irq_enc_if.sv
// prio_irq_enc_if
// Groups the request, grant and cascade signals of the priority encoder.
// The master modport belongs to the request source and service engine. The
// slave modport belongs to the encoder.
//   ei      : enable input; 0 blocks all grants
//   req     : N level request lines; each rising edge creates a pending event
//   mask    : N channel masks; 1 excludes that channel from arbitration
//   ack     : service engine accepts the current grant
//   clr_ovf : synchronous clear of the sticky overflow flag
//   y       : granted channel index (W bits)
//   valid   : y holds a committed grant
//   gs      : group select; same as valid
//   eo      : enable output for the next lower-priority stage
//   ovf     : sticky flag; a request edge arrived on a channel already pending
interface prio_irq_enc_if #(
    parameter int N = 8
) ();
    localparam int W = $clog2(N);

    logic         ei;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         clr_ovf;
    logic [W-1:0] y;
    logic         valid;
    logic         gs;
    logic         eo;
    logic         ovf;

    modport master (
        output ei, req, mask, ack, clr_ovf,
        input  y, valid, gs, eo, ovf
    );

    modport slave (
        input  ei, req, mask, ack, clr_ovf,
        output y, valid, gs, eo, ovf
    );
endinterface

// File: rtl/prio_irq_enc.sv
// prio_irq_enc
// This is a registered priority encoder in the style of the CD4532, with a
// parametrised number of channels. A rising edge on a request line is stored
// in a pending register. The encoder grants one pending, unmasked channel at
// a time through a valid/ack handshake. It keeps the CD4532-style EI/GS/EO
// signals so that several blocks can be cascaded.
//   N    : number of request lines (2..256)
//   MODE : 0 = fixed priority (highest index wins), 1 = round-robin
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   if_bus  : slave side of prio_irq_enc_if (ei/req/mask/ack/clr_ovf in;
//             y/valid/gs/eo/ovf out)
module prio_irq_enc #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    prio_irq_enc_if.slave if_bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_req_q;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_y;
    logic         r_valid;
    logic         r_eo;
    logic         r_ovf;

    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_elig;
    logic         w_accept;
    logic [W-1:0] w_sel;

    // Returns the k-th channel below p, wrapping modulo N (k = 1..N).
    function automatic int rr_index(input int p, input int k);
        return (k <= p) ? (p - k) : (p + N - k);
    endfunction

    // A grant is accepted only while it is still enabled. If ei drops in the
    // same cycle as ack, the abort wins and the pending bit stays set.
    assign w_accept = r_valid & if_bus.ack & if_bus.ei;
    assign w_rise   = if_bus.req & ~r_req_q;
    assign w_clr    = w_accept ? (N'(1) << r_y) : '0;
    assign w_elig   = r_pending & ~if_bus.mask;

    // Channel selection. Both loops write w_sel in scan order, so the last
    // write is the channel with the highest priority. In round-robin mode the
    // scan starts at ptr-1 and moves downward with wrap. Iterating k from N
    // down to 1 makes the nearest candidate the final write.
    always_comb begin
        w_sel = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (w_elig[i]) w_sel = W'(i);
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (w_elig[rr_index(int'(r_ptr), k)]) w_sel = W'(rr_index(int'(r_ptr), k));
            end
        end
    end

    // Edge capture, pending bookkeeping, overflow flag, cascade output and the
    // grant FSM. Edge capture runs every cycle, whatever the value of ei. If a
    // new edge and an accept hit the same channel in one cycle, the new edge
    // wins and the channel stays pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_req_q   <= '0;
            r_pending <= '0;
            r_ptr     <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_eo      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_req_q   <= if_bus.req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_eo      <= if_bus.ei & (w_elig == '0);

            if (if_bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end else if ((w_rise & r_pending & ~w_clr) != '0) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (if_bus.ei && (w_elig != '0)) begin
                        r_y     <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!if_bus.ei) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (if_bus.ack) begin
                        r_ptr   <= r_y;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_bus.y     = r_y;
    assign if_bus.valid = r_valid;
    assign if_bus.gs    = r_valid;
    assign if_bus.eo    = r_eo;
    assign if_bus.ovf   = r_ovf;
endmodule

// File: tb/tb_prio_irq_enc.sv
// tb_prio_irq_enc
// This bench uses directed stimulus with expected values worked out by hand.
// It drives three encoders in parallel from shared stimulus:
//   bus0 : N=8, fixed priority
//   bus1 : N=8, round-robin
//   bus2 : N=5, round-robin (N is not a power of two)
// Every scenario starts from reset and checks only the encoders it targets.
module tb_prio_irq_enc;
    logic       clk;
    logic       rst_n;
    logic       ei;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_ovf;

    int errors;
    int checks;

    prio_irq_enc_if #(.N(8)) bus0 ();
    prio_irq_enc_if #(.N(8)) bus1 ();
    prio_irq_enc_if #(.N(5)) bus2 ();

    assign bus0.ei = ei;  assign bus0.req = req;      assign bus0.mask = mask;
    assign bus0.ack = ack; assign bus0.clr_ovf = clr_ovf;
    assign bus1.ei = ei;  assign bus1.req = req;      assign bus1.mask = mask;
    assign bus1.ack = ack; assign bus1.clr_ovf = clr_ovf;
    assign bus2.ei = ei;  assign bus2.req = req[4:0]; assign bus2.mask = mask[4:0];
    assign bus2.ack = ack; assign bus2.clr_ovf = clr_ovf;

    prio_irq_enc #(.N(8), .MODE(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .if_bus(bus0));
    prio_irq_enc #(.N(8), .MODE(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .if_bus(bus1));
    prio_irq_enc #(.N(5), .MODE(1)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .if_bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances one clock edge. The bench then observes and drives 1 time
    // unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ei = 1'b0; req = '0; mask = '0; ack = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        if (bus0.valid !== 1'b0 || bus0.gs !== 1'b0 || bus0.eo !== 1'b0 || bus0.ovf !== 1'b0 || bus0.y !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_values: valid=%b gs=%b eo=%b ovf=%b y=%0d, all must be 0", bus0.valid, bus0.gs, bus0.eo, bus0.ovf, bus0.y);
        end
        checks++;
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        if (bus0.valid !== 1'b0 || bus0.gs !== 1'b0 || bus0.eo !== 1'b0) begin
            errors++; $display("[TB] FAIL disabled_no_grant: valid=%b gs=%b eo=%b, required 0 0 0", bus0.valid, bus0.gs, bus0.eo);
        end
        checks++;
        ei = 1'b1;
        tick();
        if (bus0.valid !== 1'b1 || bus0.gs !== 1'b1 || bus0.y !== 3'd3) begin
            errors++; $display("[TB] FAIL enable_grant: valid=%b gs=%b y=%0d, required 1 1 3", bus0.valid, bus0.gs, bus0.y);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (bus0.valid !== 1'b0 || bus0.eo !== 1'b0) begin
            errors++; $display("[TB] FAIL ack_edge: valid=%b eo=%b, required 0 0", bus0.valid, bus0.eo);
        end
        checks++;
        tick();
        if (bus0.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL eo_after_ack: eo=%b, required 1", bus0.eo);
        end
        checks++;
        // An asynchronous reset in the middle of a grant drops every output
        // at once, and the pending event is lost.
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        if (bus0.valid !== 1'b1 || bus0.y !== 3'd4) begin
            errors++; $display("[TB] FAIL pre_reset_grant: valid=%b y=%0d, required 1 4", bus0.valid, bus0.y);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (bus0.valid !== 1'b0 || bus0.gs !== 1'b0 || bus0.y !== 3'd0) begin
            errors++; $display("[TB] FAIL async_reset: valid=%b gs=%b y=%0d, required 0 0 0", bus0.valid, bus0.gs, bus0.y);
        end
        checks++;
        #1 rst_n = 1'b1;
        tick();
        tick();
        if (bus0.valid !== 1'b0 || bus0.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL pending_lost: valid=%b eo=%b, required 0 1", bus0.valid, bus0.eo);
        end
        checks++;
    endtask

    task automatic test_fixed_priority();
        $display("[TB] test_fixed_priority");
        do_reset();
        ei = 1'b1;
        req = 8'h81;
        tick();
        req = 8'h00;
        tick();
        if (bus0.valid !== 1'b1 || bus0.y !== 3'd7) begin
            errors++; $display("[TB] FAIL fixed_first: valid=%b y=%0d, required 1 7", bus0.valid, bus0.y);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (bus0.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL fixed_idle_gap: valid=%b, required 0", bus0.valid);
        end
        checks++;
        tick();
        if (bus0.valid !== 1'b1 || bus0.y !== 3'd0) begin
            errors++; $display("[TB] FAIL fixed_second: valid=%b y=%0d, required 1 0", bus0.valid, bus0.y);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        if (bus0.valid !== 1'b0 || bus0.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL fixed_drained: valid=%b eo=%b, required 0 1", bus0.valid, bus0.eo);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        $display("[TB] test_round_robin");
        do_reset();
        ei = 1'b1;
        req = 8'h88;
        tick();
        req = 8'h00;
        tick();
        if (bus1.y !== 3'd7 || bus1.valid !== 1'b1 || bus0.y !== 3'd7) begin
            errors++; $display("[TB] FAIL rr_first: rr y=%0d valid=%b fixed y=%0d, required 7 1 7", bus1.y, bus1.valid, bus0.y);
        end
        checks++;
        // Pulsing req[7] again in the ack cycle must leave channel 7 pending.
        req = 8'h80;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        if (bus1.valid !== 1'b0 || bus1.ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL rr_accept: valid=%b ovf=%b, required 0 0", bus1.valid, bus1.ovf);
        end
        checks++;
        tick();
        if (bus1.y !== 3'd3 || bus1.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rr_second: y=%0d valid=%b, required 3 1", bus1.y, bus1.valid);
        end
        checks++;
        if (bus0.y !== 3'd7 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL fixed_regrant: y=%0d valid=%b, required 7 1", bus0.y, bus0.valid);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        if (bus1.y !== 3'd7 || bus1.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rr_third: y=%0d valid=%b, required 7 1", bus1.y, bus1.valid);
        end
        checks++;
        if (bus0.y !== 3'd3 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL fixed_third: y=%0d valid=%b, required 3 1", bus0.y, bus0.valid);
        end
        checks++;
    endtask

    task automatic test_mask();
        $display("[TB] test_mask");
        do_reset();
        ei = 1'b1;
        mask = 8'h80;
        req = 8'h81;
        tick();
        req = 8'h00;
        tick();
        if (bus0.y !== 3'd0 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL mask_grant: y=%0d valid=%b, required 0 1", bus0.y, bus0.valid);
        end
        checks++;
        mask = 8'h01;
        tick();
        mask = 8'h81;
        tick();
        if (bus0.y !== 3'd0 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL mask_committed: y=%0d valid=%b, required 0 1", bus0.y, bus0.valid);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        if (bus0.valid !== 1'b0 || bus0.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL mask_blocks: valid=%b eo=%b, required 0 1", bus0.valid, bus0.eo);
        end
        checks++;
        mask = 8'h00;
        tick();
        if (bus0.y !== 3'd7 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL mask_release: y=%0d valid=%b, required 7 1", bus0.y, bus0.valid);
        end
        checks++;
    endtask

    task automatic test_abort();
        $display("[TB] test_abort");
        do_reset();
        ei = 1'b1;
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        if (bus0.y !== 3'd5 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pre: y=%0d valid=%b, required 5 1", bus0.y, bus0.valid);
        end
        checks++;
        ei = 1'b0;
        tick();
        ei = 1'b1;
        if (bus0.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_drop: valid=%b, required 0", bus0.valid);
        end
        checks++;
        tick();
        if (bus0.y !== 3'd5 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_regrant: y=%0d valid=%b, required 5 1", bus0.y, bus0.valid);
        end
        checks++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        if (bus0.valid !== 1'b0 || bus0.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_drained: valid=%b eo=%b, required 0 1", bus0.valid, bus0.eo);
        end
        checks++;
    endtask

    task automatic test_collision();
        $display("[TB] test_collision");
        do_reset();
        ei = 1'b1;
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        if (bus0.y !== 3'd2 || bus0.ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL coll_grant: y=%0d ovf=%b, required 2 0", bus0.y, bus0.ovf);
        end
        checks++;
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        if (bus0.ovf !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_set: ovf=%b, required 1", bus0.ovf);
        end
        checks++;
        clr_ovf = 1'b1;
        tick();
        if (bus0.ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL ovf_clear: ovf=%b, required 0", bus0.ovf);
        end
        checks++;
        // A clear takes priority over a new set in the same cycle.
        req = 8'h04;
        tick();
        req = 8'h00;
        clr_ovf = 1'b0;
        if (bus0.ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL ovf_clear_priority: ovf=%b, required 0", bus0.ovf);
        end
        checks++;
        tick();
        req = 8'h04;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        if (bus0.valid !== 1'b0 || bus0.ovf !== 1'b0) begin
            errors++; $display("[TB] FAIL ack_cycle_pulse: valid=%b ovf=%b, required 0 0", bus0.valid, bus0.ovf);
        end
        checks++;
        tick();
        if (bus0.y !== 3'd2 || bus0.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL ack_cycle_regrant: y=%0d valid=%b, required 2 1", bus0.y, bus0.valid);
        end
        checks++;
    endtask

    task automatic test_non_pow2();
        logic [2:0] expSeq [5] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        $display("[TB] test_non_pow2");
        do_reset();
        ei = 1'b1;
        req = 8'h1F;
        tick();
        req = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (bus2.y !== expSeq[i] || bus2.valid !== 1'b1) begin
                errors++; $display("[TB] FAIL n5_rr_%0d: y=%0d valid=%b, required %0d 1", i, bus2.y, bus2.valid, expSeq[i]);
            end
            checks++;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
        end
        if (bus2.valid !== 1'b0 || bus2.eo !== 1'b1) begin
            errors++; $display("[TB] FAIL n5_drained: valid=%b eo=%b, required 0 1", bus2.valid, bus2.eo);
        end
        checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_mask();
        test_abort();
        test_collision();
        test_non_pow2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
